fmul_result_queue: RTL and testbench

//  Registered fix-up and writeback queue directly downstream of the fmul/round datapath.
//  - Captures the rounded product together with both source operands and a tag.
//  - Fixes special-case encodings: NaN, infinity and zero operands, plus overflow/underflow results.
//  - Produces per-result IEEE flags and buffers results in a FIFO with valid/ready on both sides.
//  - Keeps a sticky fflags accumulator for the register file.

---
 rtl/fmul_result_queue_if.sv | 24 ++
 rtl/fmul_result_queue.sv | 78 +++++++
 tb/tb_fmul_result_queue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fmul_result_queue_if.sv
// fmul_result_queue_if: producer and consumer handshake channels of the fmul result queue
interface fmul_result_queue_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_num1;
    logic [31:0]      in_num2;
    logic [31:0]      in_result;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [4:0]       out_flags;
    modport master (
        output in_valid, in_num1, in_num2, in_result, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_flags
    );
    modport slave (
        input  in_valid, in_num1, in_num2, in_result, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_flags
    );
endinterface

// File: rtl/fmul_result_queue.sv
// fmul_result_queue: special-case fix-up, IEEE flags and FIFO buffering of fmul results
module fmul_result_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    fmul_result_queue_if.slave     q,
    input  logic                   fflags_clr,
    output logic [$clog2(DEPTH):0] count,
    output logic [4:0]             fflags_acc
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]      res_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [4:0]       flg_mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             push, pop, s, nan1, nan2, snan, inf1, inf2, zero1, zero2, rof, ruf, nv_case;
    logic [31:0]      fix;
    logic [4:0]       flg;
    assign q.in_ready   = count != (AW+1)'(DEPTH);
    assign q.out_valid  = count != '0;
    assign q.out_result = res_mem[rptr];
    assign q.out_tag    = tag_mem[rptr];
    assign q.out_flags  = flg_mem[rptr];
    assign push = q.in_valid && q.in_ready;
    assign pop  = q.out_valid && q.out_ready;
    // Operand classes are checked in priority order; earlier cases shadow later ones.
    always_comb begin
        s       = q.in_num1[31] ^ q.in_num2[31];
        nan1    = (&q.in_num1[30:23]) && (|q.in_num1[22:0]);
        nan2    = (&q.in_num2[30:23]) && (|q.in_num2[22:0]);
        snan    = (nan1 && !q.in_num1[22]) || (nan2 && !q.in_num2[22]);
        inf1    = (&q.in_num1[30:23]) && !(|q.in_num1[22:0]);
        inf2    = (&q.in_num2[30:23]) && !(|q.in_num2[22:0]);
        zero1   = !(|q.in_num1[30:23]);
        zero2   = !(|q.in_num2[30:23]);
        rof     = &q.in_result[30:23];
        ruf     = !(|q.in_result[30:23]);
        nv_case = (inf1 && zero2) || (inf2 && zero1);
        fix = (nan1 || nan2 || nv_case) ? 32'h7FC0_0000 :
              (inf1 || inf2 || (!zero1 && !zero2 && rof)) ? {s, 8'hFF, 23'b0} :
              (zero1 || zero2 || ruf) ? {s, 31'b0} : q.in_result;
        flg = (nan1 || nan2) ? {snan, 4'b0} :
              nv_case ? 5'b10000 :
              (inf1 || inf2 || zero1 || zero2) ? 5'b00000 :
              rof ? 5'b00101 :
              ruf ? 5'b00011 : 5'b00000;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            fflags_acc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                res_mem[i] <= '0;
                tag_mem[i] <= '0;
                flg_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                res_mem[wptr] <= fix;
                tag_mem[wptr] <= q.in_tag;
                flg_mem[wptr] <= flg;
                wptr          <= wptr + AW'(1);
            end
            if (pop)
                rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            // A clear coinciding with a dequeue keeps only the dequeued entry's flags.
            if (pop)
                fflags_acc <= (fflags_clr ? 5'b0 : fflags_acc) | q.out_flags;
            else if (fflags_clr)
                fflags_acc <= '0;
        end
    end
endmodule

// File: tb/tb_fmul_result_queue.sv
// tb_fmul_result_queue: directed and randomized checks of fmul_result_queue against a queue-based model
module tb_fmul_result_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
    typedef struct {
        logic [31:0]      r;
        logic [TAG_W-1:0] t;
        logic [4:0]       f;
    } ent_t;
    logic clk = 0, rst = 1, fflags_clr = 0;
    logic [$clog2(DEPTH):0] count;
    logic [4:0] fflags_acc;
    int n_chk = 0, n_fail = 0;
    ent_t mq[$];
    logic [4:0] acc = 0;
    fmul_result_queue_if #(.TAG_W(TAG_W)) bus();
    fmul_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .q(bus), .fflags_clr(fflags_clr), .count(count), .fflags_acc(fflags_acc)
    );
    always #5 clk = ~clk;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    // Reference: returns {flags, result}, straight from the case list.
    function automatic logic [36:0] ref_fix(logic [31:0] a, logic [31:0] b, logic [31:0] r);
        logic sg, an, bn, ai, bi, az, bz;
        sg = a[31] ^ b[31];
        an = a[30:23] == 8'hFF && a[22:0] != 0;
        bn = b[30:23] == 8'hFF && b[22:0] != 0;
        ai = a[30:23] == 8'hFF && a[22:0] == 0;
        bi = b[30:23] == 8'hFF && b[22:0] == 0;
        az = a[30:23] == 8'h00;
        bz = b[30:23] == 8'h00;
        if (an || bn) return {((an && !a[22]) || (bn && !b[22])) ? 5'b10000 : 5'b00000, 32'h7FC00000};
        if ((ai && bz) || (bi && az)) return {5'b10000, 32'h7FC00000};
        if (ai || bi) return {5'b00000, sg, 8'hFF, 23'b0};
        if (az || bz) return {5'b00000, sg, 31'b0};
        if (r[30:23] == 8'hFF) return {5'b00101, sg, 8'hFF, 23'b0};
        if (r[30:23] == 8'h00) return {5'b00011, sg, 31'b0};
        return {5'b00000, r};
    endfunction
    task automatic compare();
        check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        check("in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
        check("count", 32'(count), 32'(mq.size()));
        check("fflags_acc", 32'(fflags_acc), 32'(acc));
        if (mq.size() != 0) begin
            check("out_result", bus.out_result, mq[0].r);
            check("out_tag", 32'(bus.out_tag), 32'(mq[0].t));
            check("out_flags", 32'(bus.out_flags), 32'(mq[0].f));
        end
    endtask
    task automatic cycle();
        logic pu, po;
        logic [36:0] x;
        ent_t e;
        pu = bus.in_valid && mq.size() < DEPTH;
        po = bus.out_ready && mq.size() > 0;
        x = ref_fix(bus.in_num1, bus.in_num2, bus.in_result);
        if (po) begin
            acc = (fflags_clr ? 5'b0 : acc) | mq[0].f;
            void'(mq.pop_front());
        end else if (fflags_clr) acc = 0;
        if (pu) begin
            e.r = x[31:0]; e.t = bus.in_tag; e.f = x[36:32];
            mq.push_back(e);
        end
        @(posedge clk); #1;
        compare();
    endtask
    task automatic push(logic [31:0] a, logic [31:0] b, logic [31:0] r, logic [TAG_W-1:0] t);
        bus.in_valid = 1; bus.in_num1 = a; bus.in_num2 = b; bus.in_result = r; bus.in_tag = t;
        cycle();
        bus.in_valid = 0;
    endtask
    task automatic pop1();
        bus.out_ready = 1;
        cycle();
        bus.out_ready = 0;
    endtask
    function automatic logic [31:0] pick_op();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h3F800000;
            1: v = 32'h7F800000;
            2: v = 32'h00000000;
            3: v = 32'h7F800001;
            4: v = 32'h7FC00000;
            5: v = {1'b0, 8'h00, 23'($urandom)};
            default: v = $urandom;
        endcase
        v[31] = 1'($urandom);
        return v;
    endfunction
    function automatic logic [31:0] pick_res();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0: v[30:23] = 8'hFF;
            1: v[30:23] = 8'h00;
            default: ;
        endcase
        return v;
    endfunction
    initial begin
        bus.in_valid = 0; bus.out_ready = 0; bus.in_num1 = 0; bus.in_num2 = 0; bus.in_result = 0; bus.in_tag = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        compare();
        check("rst_result", bus.out_result, 32'h0);
        check("rst_tag", 32'(bus.out_tag), 32'h0);
        check("rst_flags", 32'(bus.out_flags), 32'h0);
        push(32'h3F800000, 32'h40000000, 32'h40000000, 5'd1);
        check("t1_result", bus.out_result, 32'h40000000);
        check("t1_flags", 32'(bus.out_flags), 32'h00);
        check("t1_count", 32'(count), 32'd1);
        pop1();
        push(32'h7F800000, 32'h00000000, 32'h12345678, 5'd2);
        check("t2_result", bus.out_result, 32'h7FC00000);
        check("t2_flags", 32'(bus.out_flags), 32'h10);
        pop1();
        push(32'h7F800001, 32'h3F800000, 32'h3F800000, 5'd3);
        check("t3_result", bus.out_result, 32'h7FC00000);
        check("t3_flags", 32'(bus.out_flags), 32'h10);
        pop1();
        fflags_clr = 1; cycle(); fflags_clr = 0;
        check("clr_acc", 32'(fflags_acc), 32'h0);
        push(32'h7F000000, 32'h40000000, 32'h7F800000, 5'd4);
        check("t4_result", bus.out_result, 32'h7F800000);
        check("t4_flags", 32'(bus.out_flags), 32'h05);
        push(32'h00800000, 32'h00800000, 32'h00000000, 5'd5);
        check("t5_count", 32'(count), 32'd2);
        pop1();
        check("t5_result", bus.out_result, 32'h00000000);
        check("t5_flags", 32'(bus.out_flags), 32'h03);
        pop1();
        check("t7_acc", 32'(fflags_acc), 32'h07);
        push(32'h7F800000, 32'h00000000, 32'h0, 5'd6);
        fflags_clr = 1; pop1(); fflags_clr = 0;
        check("t7_clr_pop", 32'(fflags_acc), 32'h10);
        for (int i = 0; i < 4; i++) push(32'h3F800000, 32'h3F800000, 32'h3F800000, 5'(10 + i));
        check("t6_full_ready", 32'(bus.in_ready), 32'h0);
        check("t6_full_count", 32'(count), 32'd4);
        bus.in_valid = 1; bus.in_tag = 5'd14; bus.out_ready = 1;
        cycle();
        check("t6_pop_only", 32'(count), 32'd3);
        check("t6_ready_back", 32'(bus.in_ready), 32'h1);
        check("t6_tag11", 32'(bus.out_tag), 32'd11);
        cycle();
        check("t6_pushpop", 32'(count), 32'd3);
        bus.in_valid = 0;
        for (int i = 12; i <= 14; i++) begin
            check("t6_order", 32'(bus.out_tag), 32'(i));
            cycle();
        end
        bus.out_ready = 0;
        for (int i = 0; i < 3; i++) push(32'h40000000, 32'h40000000, 32'h40800000, 5'(20 + i));
        #2 rst = 1;
        #1;
        check("t8_valid", 32'(bus.out_valid), 32'h0);
        check("t8_count", 32'(count), 32'h0);
        check("t8_ready", 32'(bus.in_ready), 32'h1);
        mq.delete(); acc = 0;
        @(posedge clk); #1 rst = 0;
        compare();
        check("t8_result", bus.out_result, 32'h0);
        for (int n = 0; n < 400; n++) begin
            bus.in_valid = 1'($urandom_range(0, 2) != 0);
            bus.out_ready = 1'($urandom_range(0, 2) == 0 || n > 380);
            fflags_clr = 1'($urandom_range(0, 9) == 0);
            bus.in_num1 = pick_op();
            bus.in_num2 = pick_op();
            bus.in_result = pick_res();
            bus.in_tag = 5'($urandom);
            cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
